// File: rtl/block_fetch_ctrl_pkg.sv
// Shared constants and types for the block fetch controller: counter geometry,
// default burst length and the FSM state encoding.
package block_fetch_ctrl_pkg;

  localparam logic [15:0] BLK_STRIDE     = 16'h0200;
  localparam logic [15:0] BLK_RESET_BASE = 16'h0300;
  localparam int          BURST_LEN_DEF  = 8;
  localparam int          IDX_W          = 10;  // word index, wide enough for 0..511

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_ADV  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_OUT  = ST_OUT,
    S_ADV  = ST_ADV
  } state_e;

endpackage

// File: rtl/block_fetch_ctrl_if.sv
// Memory read port (req/gnt/rvalid) and output stream (valid/ready) of the
// block fetch controller; master is the controller, slave is memory plus sink.
interface block_fetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/block_fetch_ctrl_addr_gen.sv
// Read address generator: base + word index truncated to ADDR_W, with the
// carry-out reported so the controller can flag a wrap past the top of memory.
module fetch_addr_gen
  import block_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int IDX_WID = IDX_W
) (
  input  logic [ADDR_W-1:0]  base_i,
  input  logic [IDX_WID-1:0] idx_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               carry_o
);

  logic [ADDR_W:0] sum;

  always_comb begin
    sum     = {1'b0, base_i} + {{(ADDR_W + 1 - IDX_WID){1'b0}}, idx_i};
    addr_o  = sum[ADDR_W-1:0];
    carry_o = sum[ADDR_W];
  end

endmodule

// File: rtl/block_fetch_ctrl.sv
// Fetches one block of BURST_LEN words starting at the counter's base, streams
// them out one at a time, then pulses count_en to advance the block counter.
module block_fetch_ctrl
  import block_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] base_addr,
  block_fetch_ctrl_if.master bus,
  output logic              count_en,
  output logic              busy,
  output logic              err_wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              count_en_q;
  logic              err_wrap_q;

  logic [ADDR_W-1:0] gen_base_d;
  logic [IDX_W-1:0]  idx_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              wrap_d;

  // The next request is either word 0 of a new block or the following word.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gen_base_d = base_q;
    idx_d      = idx_q + IDX_W'(1);
    if (state_q == S_IDLE) begin
      gen_base_d = base_addr;
      idx_d      = '0;
    end
  end

  fetch_addr_gen #(
    .ADDR_W  (ADDR_W),
    .IDX_WID (IDX_W)
  ) u_addr_gen (
    .base_i  (gen_base_d),
    .idx_i   (idx_d),
    .addr_o  (mem_addr_d),
    .carry_o (wrap_d)
  );

  // NOTE: reset is sampled on the clock edge and wins over every other input;
  // all state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      count_en_q  <= 1'b0;
      err_wrap_q  <= 1'b0;
    end else begin
      count_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            base_q     <= base_addr;
            idx_q      <= idx_d;
            err_wrap_q <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_d;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.mem_rdata;
            out_last_q  <= (idx_q == LAST_IDX);
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              count_en_q <= 1'b1;
              state_q    <= S_ADV;
            end else begin
              idx_q      <= idx_d;
              mem_req_q  <= 1'b1;
              mem_addr_q <= mem_addr_d;
              // Sticky: once the block crosses the top of memory it stays flagged.
              if (wrap_d) err_wrap_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_ADV:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign count_en      = count_en_q;
  assign err_wrap      = err_wrap_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_block_fetch_ctrl.sv
// Scoreboard bench for block_fetch_ctrl: stimulus queues expected requests and
// output words, an independent monitor pops and compares on each handshake.
module tb_block_fetch_ctrl;
  import block_fetch_ctrl_pkg::*;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        wrap;
  } req_exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } out_exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [15:0] base_addr = '0;
  logic        count_en, busy, err_wrap;

  block_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  block_fetch_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .base_addr (base_addr),
    .bus       (bus_if),
    .count_en  (count_en),
    .busy      (busy),
    .err_wrap  (err_wrap)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  req_exp_t req_q[$];
  out_exp_t out_q[$];
  int exp_cen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[15:8]};
  endfunction

  // Memory + sink model: grant immediately, return data the next cycle,
  // optional out_ready stall on one word and optional spurious gnt/rvalid.
  logic        pending = 1'b0;
  logic [15:0] pend_addr = '0;
  logic        spur = 1'b0;
  int          stall_at = -1;
  int          stall_left = 0;
  int          n_hs = 0;

  initial begin
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = '0;
    bus_if.out_ready  = 1'b1;
    forever begin
      @(negedge CLK);
      if (pending) begin
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = mem_word(pend_addr);
        pending           = 1'b0;
      end else begin
        bus_if.mem_rvalid = spur;
        bus_if.mem_rdata  = spur ? 16'hDEAD : 16'h0000;
      end
      bus_if.mem_gnt = spur | (bus_if.mem_req === 1'b1);
      if (bus_if.mem_req === 1'b1) begin
        pending   = 1'b1;
        pend_addr = bus_if.mem_addr;
      end
      if (bus_if.out_valid === 1'b1 && n_hs == stall_at && stall_left > 0) begin
        bus_if.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus_if.out_ready = 1'b1;
      end
    end
  end

  // Monitor: samples just after the falling edge, when inputs and outputs are settled.
  logic        prev_req = 0, prev_gnt = 0, prev_valid = 0, prev_ready = 0;
  logic        prev_rst = 0, prev_cen = 0, prev_last = 0;
  logic [15:0] prev_addr = '0, prev_data = '0;
  int          n_gnt = 0, n_cen = 0, last_hs_edge = -1, cen_edge = -1;

  initial begin
    req_exp_t re;
    out_exp_t oe;
    forever begin
      @(negedge CLK);
      #1;
      if (RESET && prev_rst) begin
        if (prev_req && !prev_gnt) begin
          check("req_hold", bus_if.mem_req, 1);
          check("addr_hold", bus_if.mem_addr, prev_addr);
        end
        if (prev_valid && !prev_ready) begin
          check("valid_hold", bus_if.out_valid, 1);
          check("data_hold", bus_if.out_data, prev_data);
          check("last_hold", bus_if.out_last, prev_last);
        end
      end
      if (bus_if.out_last === 1'b1) check("last_qualified", bus_if.out_valid, 1);
      if (bus_if.mem_req === 1'b1) check("one_outstanding", bus_if.out_valid, 0);
      if (bus_if.mem_req === 1'b1 && bus_if.mem_gnt === 1'b1) begin
        n_gnt++;
        check("req_expected", 32'(req_q.size() > 0), 1);
        if (req_q.size() > 0) begin
          re = req_q.pop_front();
          check("mem_addr", bus_if.mem_addr, re.addr);
          check("err_wrap", err_wrap, re.wrap);
        end
      end
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
        n_hs++;
        check("out_expected", 32'(out_q.size() > 0), 1);
        if (out_q.size() > 0) begin
          oe = out_q.pop_front();
          check("out_data", bus_if.out_data, oe.data);
          check("out_last", bus_if.out_last, oe.last);
        end
        if (bus_if.out_last === 1'b1) last_hs_edge = cyc + 1;
      end
      if (count_en === 1'b1) begin
        n_cen++;
        cen_edge = cyc;
        check("cen_after_last", cyc, last_hs_edge);
        check("cen_width", prev_cen, 0);
      end
      prev_req   = bus_if.mem_req;
      prev_gnt   = bus_if.mem_gnt;
      prev_addr  = bus_if.mem_addr;
      prev_valid = bus_if.out_valid;
      prev_ready = bus_if.out_ready;
      prev_data  = bus_if.out_data;
      prev_last  = bus_if.out_last;
      prev_cen   = count_en;
      prev_rst   = RESET;
    end
  end

  task automatic start_burst(input logic [15:0] b, output int s_edge);
    logic [16:0] s;
    for (int i = 0; i < BURST_LEN; i++) begin
      s = {1'b0, b} + 17'(i);
      req_q.push_back('{addr: s[15:0], wrap: s[16]});
      out_q.push_back('{data: mem_word(s[15:0]), last: (i == BURST_LEN - 1)});
    end
    exp_cen++;
    @(negedge CLK);
    START     = 1'b1;
    base_addr = b;
    s_edge    = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_bursts(input int target);
    for (int i = 0; i < 400 && n_cen < target; i++) @(negedge CLK);
    check("burst_complete", n_cen, target);
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_req"},   bus_if.mem_req, 0);
    check({tag, "_mem_addr"},  bus_if.mem_addr, 0);
    check({tag, "_out_valid"}, bus_if.out_valid, 0);
    check({tag, "_out_data"},  bus_if.out_data, 0);
    check({tag, "_out_last"},  bus_if.out_last, 0);
    check({tag, "_count_en"},  count_en, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_err_wrap"},  err_wrap, 0);
  endtask

  initial begin
    int s_edge;
    int g0;

    // T1: reset held two cycles with START asserted.
    RESET = 1'b0;
    START = 1'b1;
    base_addr = BLK_RESET_BASE;
    repeat (2) @(negedge CLK);
    check_idle("reset");
    RESET = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    check("reset_start_ignored", busy, 0);

    // T2: basic burst at the counter's reset base, no stalls.
    start_burst(BLK_RESET_BASE, s_edge);
    check("busy_in_burst", busy, 1);
    wait_bursts(exp_cen);
    check("cen_latency", cen_edge - s_edge, 24);
    check("busy_after_burst", busy, 0);
    check("cen_dropped", count_en, 0);

    // T3: out_ready low for 5 cycles on word 3.
    stall_at   = n_hs + 2;
    stall_left = 5;
    start_burst(16'h1230, s_edge);
    wait_bursts(exp_cen);
    check("stall_applied", stall_left, 0);
    check("stall_latency", cen_edge - s_edge, 29);

    // T4: wrap past 0xFFFF, flag sticky until the next accepted START.
    start_burst(16'hFFFC, s_edge);
    wait_bursts(exp_cen);
    check("wrap_sticky", err_wrap, 1);
    start_burst(16'h0010, s_edge);
    wait_bursts(exp_cen);
    check("wrap_cleared", err_wrap, 0);

    // T5: reset during WAIT of word 4, then a clean burst at the next block.
    g0 = n_gnt;
    start_burst(16'h2000, s_edge);
    for (int i = 0; i < 100 && n_gnt < g0 + 4; i++) @(negedge CLK);
    check("abort_reached", n_gnt, g0 + 4);
    RESET = 1'b0;
    @(negedge CLK);
    check_idle("abort");
    RESET = 1'b1;
    req_q.delete();
    out_q.delete();
    exp_cen--;
    repeat (5) @(negedge CLK);
    check("abort_no_cen", n_cen, exp_cen);
    start_burst(BLK_RESET_BASE + BLK_STRIDE, s_edge);
    wait_bursts(exp_cen);
    check("post_abort_latency", cen_edge - s_edge, 24);

    // T6: START while busy, spurious gnt/rvalid outside REQ/WAIT.
    spur = 1'b1;
    start_burst(16'h0700, s_edge);
    repeat (4) @(negedge CLK);
    START     = 1'b1;
    base_addr = 16'h7777;
    repeat (3) @(negedge CLK);
    START = 1'b0;
    wait_bursts(exp_cen);
    spur = 1'b0;
    repeat (10) @(negedge CLK);
    check("single_cen_per_burst", n_cen, exp_cen);
    check("idle_after_robust", busy, 0);

    check("req_q_drained", req_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
